hub75_rx: RTL and testbench

HUB75_RX -- requirements
Module: hub75_rx

---
 rtl/hub75_pkg.sv | 19 +
 rtl/hub75_sync.sv | 35 +++
 rtl/hub75_rx.sv | 259 +++++++++++++++++++++++++
 tb/tb_hub75_rx.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hub75_pkg.sv
// Shared defaults, pixel type and drain-state encoding for the HUB75 receiver.
package hub75_pkg;

   localparam int DEF_PIXELS_PER_ROW = 48;
   localparam int ROW_BITS           = 5;
   localparam int COL_BITS           = 6;
   localparam int ONTIME_BITS        = 9;

   typedef struct packed {
      logic [2:0] rgb1;
      logic [2:0] rgb0;
   } pixel_t;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_DRAIN = 1'b1
   } drain_state_t;

endpackage

// File: rtl/hub75_sync.sv
// Single-bit multi-flop synchronizer with rise/fall detection on the synchronized value.
module hub75_sync
   import hub75_pkg::*;
#(
   parameter int STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q,
   output logic o_rise,
   output logic o_fall
);

   // Bits [STAGES-1:0] are the synchronizer; bit STAGES holds the previous synchronized value.
   logic [STAGES:0] sh_q;
   logic [STAGES:0] sh_d;

   always_comb begin
      sh_d = {sh_q[STAGES-1:0], i_d};
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         sh_q <= {(STAGES+1){1'b0}};
      end else begin
         sh_q <= sh_d;
      end
   end

   assign o_q    = sh_q[STAGES-1];
   assign o_rise = sh_q[STAGES-1] & ~sh_q[STAGES];
   assign o_fall = ~sh_q[STAGES-1] & sh_q[STAGES];

endmodule

// File: rtl/hub75_rx.sv
// HUB75 panel-input receiver: captures shifted rows, drains them as ready/valid pixel beats.
// Optional blank on-time measurement is built when HUB75_RX_ONTIME_EN is defined.
module hub75_rx
   import hub75_pkg::*;
#(
   parameter int PIXELS_PER_ROW = DEF_PIXELS_PER_ROW,
   parameter int SYNC_STAGES    = 2
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_data_clock,
   input  logic                   i_data_latch,
   input  logic                   i_data_blank,
   input  logic                   i_r0,
   input  logic                   i_g0,
   input  logic                   i_b0,
   input  logic                   i_r1,
   input  logic                   i_g1,
   input  logic                   i_b1,
   input  logic [ROW_BITS-1:0]    i_row_select,
   output logic                   o_px_valid,
   input  logic                   i_px_ready,
   output logic [ROW_BITS-1:0]    o_px_row,
   output logic [COL_BITS-1:0]    o_px_col,
   output logic [2:0]             o_px_rgb0,
   output logic [2:0]             o_px_rgb1,
   output logic [ONTIME_BITS-1:0] o_ontime,
   output logic                   o_ontime_valid,
   output logic                   o_overflow
);

   localparam int                  CNT_W    = $clog2(PIXELS_PER_ROW + 1);
   localparam int                  DIN_W    = ROW_BITS + 6;
   localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(PIXELS_PER_ROW - 1);

   logic clk_lvl_s, clk_rise_s, clk_fall_s;
   logic latch_lvl_s, latch_rise_s, latch_fall_s;
   logic blank_s, blank_rise_s, blank_fall_s;
   logic unused_s;

   hub75_sync #(.STAGES(SYNC_STAGES)) u_sync_clk (
      .i_clk(i_clk), .i_rst(i_rst), .i_d(i_data_clock),
      .o_q(clk_lvl_s), .o_rise(clk_rise_s), .o_fall(clk_fall_s)
   );
   hub75_sync #(.STAGES(SYNC_STAGES)) u_sync_latch (
      .i_clk(i_clk), .i_rst(i_rst), .i_d(i_data_latch),
      .o_q(latch_lvl_s), .o_rise(latch_rise_s), .o_fall(latch_fall_s)
   );
   hub75_sync #(.STAGES(SYNC_STAGES)) u_sync_blank (
      .i_clk(i_clk), .i_rst(i_rst), .i_d(i_data_blank),
      .o_q(blank_s), .o_rise(blank_rise_s), .o_fall(blank_fall_s)
   );

   // Colour and row lines take the same depth as the control lines so they stay aligned.
   logic [DIN_W-1:0] dsync_q [SYNC_STAGES];
   logic [DIN_W-1:0] dsync_d [SYNC_STAGES];
   pixel_t           pix_in_s;
   logic [ROW_BITS-1:0] row_in_s;

   always_comb begin
      dsync_d[0] = {i_row_select, i_b1, i_g1, i_r1, i_b0, i_g0, i_r0};
      for (int i = 1; i < SYNC_STAGES; i++) begin
         dsync_d[i] = dsync_q[i-1];
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            dsync_q[i] <= {DIN_W{1'b0}};
         end
      end else begin
         dsync_q <= dsync_d;
      end
   end

   assign pix_in_s = pixel_t'(dsync_q[SYNC_STAGES-1][5:0]);
   assign row_in_s = dsync_q[SYNC_STAGES-1][DIN_W-1:6];

   pixel_t               cap_q [PIXELS_PER_ROW];
   pixel_t               cap_d [PIXELS_PER_ROW];
   pixel_t               drn_q [PIXELS_PER_ROW];
   pixel_t               drn_d [PIXELS_PER_ROW];
   logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_cap_s;
   logic                 ovf_q, ovf_d, ovf_cap_s;
   logic [COL_BITS-1:0]  wr_col_s, col_nxt_s;
   drain_state_t         state_q, state_d;
   logic [ROW_BITS-1:0]  drn_row_q, drn_row_d;
   logic [COL_BITS-1:0]  drn_start_q, drn_start_d;
   logic                 vld_q, vld_d;
   logic [ROW_BITS-1:0]  row_q, row_d;
   logic [COL_BITS-1:0]  col_q, col_d;
   pixel_t               pout_q, pout_d;

   // Shift capture: the k-th shift of a row lands in column LAST_COL-k.
   always_comb begin
      cap_d     = cap_q;
      cnt_cap_s = cnt_q;
      ovf_cap_s = ovf_q;
      wr_col_s  = LAST_COL - COL_BITS'(cnt_q);
      if (clk_rise_s) begin
         if (cnt_q < CNT_W'(PIXELS_PER_ROW)) begin
            cap_d[wr_col_s] = pix_in_s;
            cnt_cap_s       = cnt_q + CNT_W'(1);
         end else begin
            ovf_cap_s = 1'b1;
         end
      end else begin
         cnt_cap_s = cnt_q;
      end
   end

   // Commit on latch (seeing the same-cycle shift) and the drain FSM that emits beats.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_cap_s;
      ovf_d       = ovf_cap_s;
      drn_d       = drn_q;
      drn_row_d   = drn_row_q;
      drn_start_d = drn_start_q;
      vld_d       = vld_q;
      row_d       = row_q;
      col_d       = col_q;
      pout_d      = pout_q;
      col_nxt_s   = col_q + COL_BITS'(1);

      case (state_q)
         ST_IDLE: begin
            if (latch_rise_s && (cnt_cap_s != {CNT_W{1'b0}})) begin
               drn_d       = cap_d;
               drn_row_d   = row_in_s;
               drn_start_d = COL_BITS'(PIXELS_PER_ROW - int'(cnt_cap_s));
               state_d     = ST_DRAIN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_DRAIN: begin
            if (!vld_q) begin
               vld_d  = 1'b1;
               row_d  = drn_row_q;
               col_d  = drn_start_q;
               pout_d = drn_q[drn_start_q];
            end else if (i_px_ready) begin
               if (col_q == LAST_COL) begin
                  vld_d   = 1'b0;
                  state_d = ST_IDLE;
               end else begin
                  col_d  = col_nxt_s;
                  pout_d = drn_q[col_nxt_s];
               end
            end else begin
               vld_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            vld_d   = 1'b0;
         end
      endcase

      if (latch_rise_s) begin
         cnt_d = {CNT_W{1'b0}};
         if (state_q == ST_DRAIN) begin
            ovf_d = 1'b1;
         end else begin
            ovf_d = ovf_cap_s;
         end
      end else begin
         cnt_d = cnt_cap_s;
      end
   end

   // Control and output registers.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= {CNT_W{1'b0}};
         ovf_q       <= 1'b0;
         drn_row_q   <= {ROW_BITS{1'b0}};
         drn_start_q <= {COL_BITS{1'b0}};
         vld_q       <= 1'b0;
         row_q       <= {ROW_BITS{1'b0}};
         col_q       <= {COL_BITS{1'b0}};
         pout_q      <= pixel_t'(6'd0);
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ovf_q       <= ovf_d;
         drn_row_q   <= drn_row_d;
         drn_start_q <= drn_start_d;
         vld_q       <= vld_d;
         row_q       <= row_d;
         col_q       <= col_d;
         pout_q      <= pout_d;
      end
   end

   // Pixel storage needs no reset: only columns written since the last count clear are drained.
   always_ff @(posedge i_clk) begin
      cap_q <= cap_d;
      drn_q <= drn_d;
   end

   assign o_px_valid = vld_q;
   assign o_px_row   = row_q;
   assign o_px_col   = col_q;
   assign o_px_rgb0  = pout_q.rgb0;
   assign o_px_rgb1  = pout_q.rgb1;
   assign o_overflow = ovf_q;

`ifdef HUB75_RX_ONTIME_EN
   logic [ONTIME_BITS-1:0] on_cnt_q, on_cnt_d, ontime_q, ontime_d;
   logic                   onv_q, onv_d;

   // Blank-low cycle counter, saturating; reported and cleared on blank rising.
   always_comb begin
      on_cnt_d = on_cnt_q;
      ontime_d = ontime_q;
      onv_d    = 1'b0;
      if (blank_rise_s) begin
         ontime_d = on_cnt_q;
         onv_d    = 1'b1;
         on_cnt_d = {ONTIME_BITS{1'b0}};
      end else if (!blank_s) begin
         if (on_cnt_q != {ONTIME_BITS{1'b1}}) begin
            on_cnt_d = on_cnt_q + ONTIME_BITS'(1);
         end else begin
            on_cnt_d = on_cnt_q;
         end
      end else begin
         on_cnt_d = on_cnt_q;
      end
   end

   // On-time registers.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         on_cnt_q <= {ONTIME_BITS{1'b0}};
         ontime_q <= {ONTIME_BITS{1'b0}};
         onv_q    <= 1'b0;
      end else begin
         on_cnt_q <= on_cnt_d;
         ontime_q <= ontime_d;
         onv_q    <= onv_d;
      end
   end

   assign o_ontime       = ontime_q;
   assign o_ontime_valid = onv_q;
   assign unused_s       = ^{clk_lvl_s, clk_fall_s, latch_lvl_s, latch_fall_s, blank_fall_s};
`else
   assign o_ontime       = {ONTIME_BITS{1'b0}};
   assign o_ontime_valid = 1'b0;
   assign unused_s       = ^{clk_lvl_s, clk_fall_s, latch_lvl_s, latch_fall_s,
                             blank_s, blank_rise_s, blank_fall_s};
`endif

endmodule

// File: tb/tb_hub75_rx.sv
// Directed + randomized bench for hub75_rx with a row-level reference model of expected beats.
module tb_hub75_rx;

   localparam int P = 48;

   logic       i_clk = 1'b0;
   logic       i_rst = 1'b0;
   logic       i_data_clock = 1'b0, i_data_latch = 1'b0, i_data_blank = 1'b1;
   logic       i_r0 = 1'b0, i_g0 = 1'b0, i_b0 = 1'b0, i_r1 = 1'b0, i_g1 = 1'b0, i_b1 = 1'b0;
   logic [4:0] i_row_select = 5'd0;
   logic       i_px_ready = 1'b0;
   logic       o_px_valid;
   logic [4:0] o_px_row;
   logic [5:0] o_px_col;
   logic [2:0] o_px_rgb0, o_px_rgb1;
   logic [8:0] o_ontime;
   logic       o_ontime_valid;
   logic       o_overflow;

   always #5 i_clk = ~i_clk;

   hub75_rx #(.PIXELS_PER_ROW(P), .SYNC_STAGES(2)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_data_clock(i_data_clock), .i_data_latch(i_data_latch), .i_data_blank(i_data_blank),
      .i_r0(i_r0), .i_g0(i_g0), .i_b0(i_b0), .i_r1(i_r1), .i_g1(i_g1), .i_b1(i_b1),
      .i_row_select(i_row_select),
      .o_px_valid(o_px_valid), .i_px_ready(i_px_ready),
      .o_px_row(o_px_row), .o_px_col(o_px_col),
      .o_px_rgb0(o_px_rgb0), .o_px_rgb1(o_px_rgb1),
      .o_ontime(o_ontime), .o_ontime_valid(o_ontime_valid),
      .o_overflow(o_overflow)
   );

   int          checks = 0;
   int          failures = 0;
   int          stall_viol = 0;
   logic [16:0] beats [$];
   logic [16:0] exp_q [$];
   logic [5:0]  px_hist [64];
   logic        prev_stall = 1'b0;
   logic [16:0] prev_beat = 17'd0;
   logic [16:0] cur_beat;

   assign cur_beat = {o_px_row, o_px_col, o_px_rgb1, o_px_rgb0};

   // Beat collector and stall-stability monitor, sampled on the falling edge.
   always @(negedge i_clk) begin
      if (!i_rst) begin
         prev_stall <= 1'b0;
      end else begin
         if (o_px_valid && i_px_ready) beats.push_back(cur_beat);
         if (prev_stall && ((o_px_valid !== 1'b1) || (cur_beat !== prev_beat)))
            stall_viol <= stall_viol + 1;
         prev_stall <= o_px_valid && !i_px_ready;
         prev_beat  <= cur_beat;
      end
   end

   initial begin
      #800000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge i_clk);
         #2;
      end
   endtask

   task automatic do_reset();
      i_rst = 1'b0;
      step(3);
      i_rst = 1'b1;
      step(3);
   endtask

   task automatic shift_px(input logic [5:0] px, input bit also_latch);
      {i_b1, i_g1, i_r1, i_b0, i_g0, i_r0} = px;
      step(2);
      i_data_clock = 1'b1;
      if (also_latch) i_data_latch = 1'b1;
      step(3);
      i_data_clock = 1'b0;
      i_data_latch = 1'b0;
      step(1);
   endtask

   task automatic shift_row(input int n, input bit fixed_en, input logic [5:0] fixed_px);
      logic [5:0] px;
      for (int k = 0; k < n; k++) begin
         px = fixed_en ? fixed_px : 6'($urandom);
         px_hist[k] = px;
         shift_px(px, 1'b0);
      end
   endtask

   task automatic latch_row(input logic [4:0] row);
      i_row_select = row;
      step(2);
      i_data_latch = 1'b1;
      step(3);
      i_data_latch = 1'b0;
      step(1);
   endtask

   // Model: shift k goes to column P-1-k; beats come out in ascending column over the kept shifts.
   task automatic expect_row(input logic [4:0] row, input int n);
      int         m;
      logic [5:0] col;
      logic [5:0] px;
      m = (n > P) ? P : n;
      for (int c = P - m; c < P; c++) begin
         col = 6'(c);
         px  = px_hist[P - 1 - c];
         exp_q.push_back({row, col, px[5:3], px[2:0]});
      end
   endtask

   task automatic compare_row(input string tag);
      int n;
      check({tag, "_count"}, 32'(beats.size()), 32'(exp_q.size()));
      n = (beats.size() < exp_q.size()) ? beats.size() : exp_q.size();
      for (int i = 0; i < n; i++) check({tag, "_beat"}, 32'(beats[i]), 32'(exp_q[i]));
      check({tag, "_idle"}, 32'(o_px_valid), 32'd0);
      beats.delete();
      exp_q.delete();
   endtask

   // mode 0: ready high, 1: alternate 1,0,1,0, 2: random.
   task automatic run_drain(input int mode, input string tag);
      int cyc;
      bit tog;
      cyc = 0;
      tog = 1'b1;
      while ((beats.size() < exp_q.size()) && (cyc < 2000)) begin
         case (mode)
            0: i_px_ready = 1'b1;
            1: begin i_px_ready = tog; tog = !tog; end
            default: i_px_ready = 1'($urandom_range(0, 1));
         endcase
         step(1);
         cyc++;
      end
      i_px_ready = 1'b1;
      step(30);
      compare_row(tag);
   endtask

   task automatic blank_test(input int low_cycles, output int pulses, output logic [8:0] val);
      i_data_blank = 1'b0;
      step(low_cycles);
      i_data_blank = 1'b1;
      pulses = 0;
      val = 9'd0;
      for (int i = 0; i < 20; i++) begin
         @(negedge i_clk);
         if (o_ontime_valid === 1'b1) begin
            pulses++;
            val = o_ontime;
         end
      end
   endtask

   initial begin
      int          n;
      int          cyc;
      int          pulses;
      logic [8:0]  val;
      logic [4:0]  row;
      logic [5:0]  px;
      int          exp_pulses;
      logic [8:0]  exp96;
      logic [8:0]  exp600;

      // Reset state.
      step(3);
      @(negedge i_clk);
      check("rst_valid", 32'(o_px_valid), 32'd0);
      check("rst_row", 32'(o_px_row), 32'd0);
      check("rst_col", 32'(o_px_col), 32'd0);
      check("rst_rgb0", 32'(o_px_rgb0), 32'd0);
      check("rst_rgb1", 32'(o_px_rgb1), 32'd0);
      check("rst_ontime", 32'(o_ontime), 32'd0);
      check("rst_ontime_valid", 32'(o_ontime_valid), 32'd0);
      check("rst_overflow", 32'(o_overflow), 32'd0);
      step(1);
      i_rst = 1'b1;
      step(5);

      // Full solid row: r0 and b1 set on every pixel, row 7.
      i_px_ready = 1'b1;
      shift_row(48, 1'b1, 6'b100_001);
      expect_row(5'd7, 48);
      latch_row(5'd7);
      run_drain(0, "solid_row7");
      check("solid_no_overflow", 32'(o_overflow), 32'd0);

      // Last shift coincides with the latch edge and must be part of the committed row.
      n = 10;
      shift_row(n - 1, 1'b0, 6'd0);
      px = 6'($urandom);
      px_hist[n - 1] = px;
      i_row_select = 5'd3;
      shift_px(px, 1'b1);
      expect_row(5'd3, n);
      run_drain(0, "same_cycle");

      // Random partial rows with random backpressure.
      for (int r = 0; r < 3; r++) begin
         n   = $urandom_range(1, 48);
         row = 5'($urandom_range(0, 31));
         shift_row(n, 1'b0, 6'd0);
         expect_row(row, n);
         latch_row(row);
         run_drain(2, "rand_row");
      end

      // Alternating ready: stalls must hold outputs, exactly 48 transfers.
      shift_row(48, 1'b0, 6'd0);
      expect_row(5'd12, 48);
      latch_row(5'd12);
      run_drain(1, "toggle_ready");
      check("toggle_stall_stable", 32'(stall_viol), 32'd0);

      // Latch with no shifts commits nothing.
      latch_row(5'd5);
      run_drain(0, "zero_shift");
      check("pre_over_overflow", 32'(o_overflow), 32'd0);

      // 50 shifts: only the first 48 are kept.
      shift_row(50, 1'b0, 6'd0);
      expect_row(5'd20, 50);
      latch_row(5'd20);
      run_drain(0, "over50");
      check("over50_overflow", 32'(o_overflow), 32'd1);

      // Second latch during a stalled drain is dropped.
      do_reset();
      check("post_rst_overflow", 32'(o_overflow), 32'd0);
      i_px_ready = 1'b0;
      shift_row(48, 1'b0, 6'd0);
      expect_row(5'd9, 48);
      latch_row(5'd9);
      cyc = 0;
      while ((o_px_valid !== 1'b1) && (cyc < 50)) begin
         step(1);
         cyc++;
      end
      check("drop_valid_up", 32'(o_px_valid), 32'd1);
      shift_row(5, 1'b0, 6'd0);
      latch_row(5'd10);
      check("drop_overflow", 32'(o_overflow), 32'd1);
      check("drop_no_early_beats", 32'(beats.size()), 32'd0);
      run_drain(0, "drop_first_row");
      check("drop_stall_stable", 32'(stall_viol), 32'd0);

      // Blank on-time measurement.
`ifdef HUB75_RX_ONTIME_EN
      exp_pulses = 1;
      exp96      = 9'd96;
      exp600     = 9'd511;
`else
      exp_pulses = 0;
      exp96      = 9'd0;
      exp600     = 9'd0;
`endif
      step(5);
      blank_test(96, pulses, val);
      check("ontime96_pulses", 32'(pulses), 32'(exp_pulses));
      check("ontime96_value", 32'(o_ontime), 32'(exp96));
      check("ontime96_pulse_value", 32'(val), 32'(exp96));
      blank_test(600, pulses, val);
      check("ontime600_pulses", 32'(pulses), 32'(exp_pulses));
      check("ontime600_value", 32'(o_ontime), 32'(exp600));

      // Reset in the middle of a drain aborts the row; the next row is clean.
      do_reset();
      i_px_ready = 1'b1;
      shift_row(48, 1'b0, 6'd0);
      latch_row(5'd14);
      cyc = 0;
      while ((beats.size() < 20) && (cyc < 500)) begin
         @(negedge i_clk);
         #1;
         cyc++;
      end
      check("midrst_reached_beat20", 32'(beats.size() >= 20), 32'd1);
      i_rst = 1'b0;
      #1;
      check("midrst_valid_low", 32'(o_px_valid), 32'd0);
      step(3);
      i_rst = 1'b1;
      beats.delete();
      step(30);
      check("midrst_no_more_beats", 32'(beats.size()), 32'd0);
      check("midrst_overflow", 32'(o_overflow), 32'd0);
      n   = $urandom_range(1, 48);
      row = 5'($urandom_range(0, 31));
      shift_row(n, 1'b0, 6'd0);
      expect_row(row, n);
      latch_row(row);
      run_drain(2, "after_midrst");
      check("final_stall_stable", 32'(stall_viol), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
